// File: rtl/vec_mem_pkg.sv
// Shared defaults and FSM state encoding for the vector memory sequencer.
package vec_mem_pkg;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STORE     = 3'd1,
    LOAD      = 3'd2,
    LOAD_WAIT = 3'd3,
    DONE      = 3'd4
  } state_e;

endpackage

// File: rtl/vector_mem_sequencer.sv
// Serialises one vector load/store into per-lane accesses on a scalar data memory
// with a synchronous one-cycle read, and reports completion to the control unit.
module vector_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Start,
  input  logic                    MemWE,
  input  logic [ADDR_W-1:0]       BaseAddr,
  input  logic [LANES*DATA_W-1:0] StoreData,
  output logic [LANES*DATA_W-1:0] LoadData,
  output logic                    Mem_Finished,
  output logic                    Busy,
  output logic [ADDR_W-1:0]       MemAddr,
  output logic                    MemWrEn,
  output logic [DATA_W-1:0]       MemWrData,
  input  logic [DATA_W-1:0]       MemRdData
);

  localparam int unsigned VEC_W = LANES * DATA_W;
  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_we_q, op_we_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [VEC_W-1:0]   store_q, store_d;
  logic [VEC_W-1:0]   shadow_q, shadow_d;
  logic [VEC_W-1:0]   load_data_q, load_data_d;
  logic               finished_q, finished_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_wr_en_q, mem_wr_en_d;
  logic [DATA_W-1:0]  mem_wr_data_q, mem_wr_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      op_we_q       <= 1'b0;
      base_q        <= '0;
      store_q       <= '0;
      shadow_q      <= '0;
      load_data_q   <= '0;
      finished_q    <= 1'b0;
      busy_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_we_q       <= op_we_d;
      base_q        <= base_d;
      store_q       <= store_d;
      shadow_q      <= shadow_d;
      load_data_q   <= load_data_d;
      finished_q    <= finished_d;
      busy_q        <= busy_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  // Next state, lane counter and load shadow capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_we_d     = op_we_q;
    base_d      = base_q;
    store_d     = store_q;
    shadow_d    = shadow_q;
    load_data_d = load_data_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_we_d = MemWE;
          base_d  = BaseAddr;
          store_d = StoreData;
          cnt_d   = '0;
          state_d = MemWE ? STORE : LOAD;
        end
      end
      STORE: begin
        if (cnt_q == LAST_LANE) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD: begin
        // Read data in this cycle belongs to the address issued one cycle earlier.
        for (int i = 0; i < int'(LANES) - 1; i++) begin
          if (cnt_q == CNT_W'(i + 1)) shadow_d[i*DATA_W +: DATA_W] = MemRdData;
        end
        if (cnt_q == LAST_LANE) begin
          cnt_d   = '0;
          state_d = LOAD_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOAD_WAIT: begin
        shadow_d[(LANES-1)*DATA_W +: DATA_W] = MemRdData;
        load_data_d = shadow_d;
        state_d     = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it.
  always_comb begin
    mem_wr_en_d   = (state_d == STORE);
    finished_d    = (state_d == DONE);
    busy_d        = (state_d != IDLE);
    mem_addr_d    = '0;
    mem_wr_data_d = '0;
    if (state_d == STORE || state_d == LOAD) begin
      mem_addr_d = base_d + ADDR_W'(cnt_d);
    end
    if (state_d == STORE) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (cnt_d == CNT_W'(i)) mem_wr_data_d = store_d[i*DATA_W +: DATA_W];
      end
    end
  end

  assign LoadData     = load_data_q;
  assign Mem_Finished = finished_q;
  assign Busy         = busy_q;
  assign MemAddr      = mem_addr_q;
  assign MemWrEn      = mem_wr_en_q;
  assign MemWrData    = mem_wr_data_q;

endmodule
